palette_arbiter: RTL and testbench

//  Round-robin arbiter sharing one registered colour-palette ROM (index -> 24-bit RGB) among NREQ requesters.

---
 rtl/palette_arbiter_pkg.sv | 17 +
 rtl/palette_arbiter_rr_pick.sv | 31 +++
 rtl/palette_arbiter.sv | 125 ++++++++++++
 tb/tb_palette_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/palette_arbiter_pkg.sv
// Shared types and constants for the palette ROM arbiter: FSM state
// encoding, palette index/colour widths and the black index/colour.
package palette_arbiter_pkg;

    localparam int PAL_IDX_W   = 4;
    localparam int PAL_COLOR_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [PAL_IDX_W-1:0]   IDX_BLACK   = 4'd7;
    localparam logic [PAL_COLOR_W-1:0] COLOR_BLACK = 24'h000000;

endpackage

// File: rtl/palette_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from NREQ-1 back to 0.
module palette_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    // Two passes replace a modulo search: upper segment first, then the wrap.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!any && req[j] && (ID_W'(j) >= ptr)) begin
                any    = 1'b1;
                winner = ID_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!any && req[j] && (ID_W'(j) < ptr)) begin
                any    = 1'b1;
                winner = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/palette_arbiter.sv
// Round-robin arbiter sharing one registered palette ROM among NREQ clients.
// Optional macro PALETTE_ARB_BLANK_EN adds a blank input that holds off grants.
module palette_arbiter
    import palette_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDX_W   = PAL_IDX_W,
    parameter int COLOR_W = PAL_COLOR_W,
    parameter int ID_W    = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
`ifdef PALETTE_ARB_BLANK_EN
    input  logic                  blank,
`endif
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*IDX_W-1:0] req_idx,
    output logic [NREQ-1:0]       gnt,
    output logic [IDX_W-1:0]      rom_sw,
    input  logic [COLOR_W-1:0]    rom_color,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [COLOR_W-1:0]    rsp_color
);

    state_t               state, state_nx;
    logic [ID_W-1:0]      cur_id, cur_id_nx;
    logic [ID_W-1:0]      rr_ptr, rr_ptr_nx;
    logic [NREQ-1:0]      gnt_nx;
    logic [IDX_W-1:0]     rom_sw_nx;
    logic                 rsp_valid_nx;
    logic [ID_W-1:0]      rsp_id_nx;
    logic [COLOR_W-1:0]   rsp_color_nx;
    logic [ID_W-1:0]      winner;
    logic                 any;
    logic                 arb_en;
    logic [IDX_W-1:0]     idx_arr [NREQ];

`ifdef PALETTE_ARB_BLANK_EN
    assign arb_en = !blank;
`else
    assign arb_en = 1'b1;
`endif

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            idx_arr[k] = req_idx[k*IDX_W +: IDX_W];
        end
    end

    palette_arbiter_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (arb_en && any) state_nx = ST_ADDR;
            ST_ADDR: state_nx = ST_DATA;
            ST_DATA: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; requests are only looked at in IDLE.
    always_comb begin
        gnt_nx       = '0;
        rom_sw_nx    = rom_sw;
        cur_id_nx    = cur_id;
        rr_ptr_nx    = rr_ptr;
        rsp_valid_nx = 1'b0;
        rsp_id_nx    = rsp_id;
        rsp_color_nx = rsp_color;
        case (state)
            ST_IDLE: begin
                if (!arb_en) begin
                    rom_sw_nx = IDX_W'(IDX_BLACK);
                end else if (any) begin
                    rom_sw_nx = idx_arr[winner];
                    gnt_nx    = NREQ'(1) << winner;
                    cur_id_nx = winner;
                end
            end
            ST_DATA: begin
                rsp_valid_nx = 1'b1;
                rsp_id_nx    = cur_id;
                rsp_color_nx = rom_color;
                rr_ptr_nx    = (cur_id == ID_W'(NREQ-1)) ? '0 : cur_id + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt       <= '0;
            rom_sw    <= '0;
            cur_id    <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_color <= COLOR_W'(COLOR_BLACK);
        end else begin
            gnt       <= gnt_nx;
            rom_sw    <= rom_sw_nx;
            cur_id    <= cur_id_nx;
            rr_ptr    <= rr_ptr_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_id    <= rsp_id_nx;
            rsp_color <= rsp_color_nx;
        end
    end

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: registered palette ROM model,
// transaction-level reference model and directed scenarios.
module tb_palette_arbiter;

    localparam int NREQ    = 4;
    localparam int IDX_W   = 4;
    localparam int COLOR_W = 24;
    localparam int ID_W    = 2;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*IDX_W-1:0] req_idx = '0;
    logic [NREQ-1:0]       gnt;
    logic [IDX_W-1:0]      rom_sw;
    logic [COLOR_W-1:0]    rom_color = '0;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [COLOR_W-1:0]    rsp_color;
    logic                  blank = 1'b0;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    palette_arbiter #(
        .NREQ(NREQ), .IDX_W(IDX_W), .COLOR_W(COLOR_W), .ID_W(ID_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
`ifdef PALETTE_ARB_BLANK_EN
        .blank     (blank),
`endif
        .req       (req),
        .req_idx   (req_idx),
        .gnt       (gnt),
        .rom_sw    (rom_sw),
        .rom_color (rom_color),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_color (rsp_color)
    );

    always #5 CLK = ~CLK;

    function automatic logic [23:0] pal(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFF0000;
            2: return 24'h00FF00;
            3: return 24'h0000FF;
            4: return 24'hFFFF00;
            5: return 24'h00FFFF;
            6: return 24'hFF00FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Registered ROM: one cycle from rom_sw to rom_color.
    always @(posedge CLK) rom_color <= pal(int'(rom_sw));

    // Reference model: a lookup occupies three edges; the response carries the
    // palette colour of the index captured at grant time.
    logic [NREQ-1:0]    exp_gnt = '0;
    logic [IDX_W-1:0]   exp_sw = '0;
    logic               exp_valid = 1'b0;
    logic [ID_W-1:0]    exp_id = '0;
    logic [COLOR_W-1:0] exp_color = '0;
    int m_busy = 0;
    int m_ptr = 0;
    int m_cur = 0;
    int m_idx = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_gnt = '0; exp_sw = '0; exp_valid = 1'b0; exp_id = '0; exp_color = '0;
            m_busy = 0; m_ptr = 0; m_cur = 0; m_idx = 0;
        end else begin
            exp_gnt   = '0;
            exp_valid = 1'b0;
            if (m_busy == 2) begin
                exp_valid = 1'b1;
                exp_id    = ID_W'(m_cur);
                exp_color = pal(m_idx);
                m_ptr     = (m_cur + 1) % NREQ;
                m_busy    = 0;
            end else if (m_busy == 1) begin
                m_busy = 2;
            end else if (blank) begin
                exp_sw = 4'd7;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (m_busy == 0 && req[j]) begin
                        m_cur   = j;
                        m_idx   = int'(req_idx[j*IDX_W +: IDX_W]);
                        exp_gnt = NREQ'(1) << j;
                        exp_sw  = IDX_W'(m_idx);
                        m_busy  = 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_gnt", 32'(gnt), 32'(exp_gnt));
            chk("model_rom_sw", 32'(rom_sw), 32'(exp_sw));
            chk("model_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("model_rsp_id", 32'(rsp_id), 32'(exp_id));
                chk("model_rsp_color", 32'(rsp_color), 32'(exp_color));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_idx(input int k, input int v);
        req_idx[k*IDX_W +: IDX_W] = IDX_W'(v);
    endtask

    initial begin
        step(2);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rom_sw", 32'(rom_sw), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_color", 32'(rsp_color), 32'h0);
        RST = 1'b0;
        chk_en = 1'b1;
        step(1);

        // Single request from requester 1, index 1.
        req = 4'b0010; set_idx(1, 1);
        step(1);
        chk("t1_gnt", 32'(gnt), 32'h2);
        chk("t1_rom_sw", 32'(rom_sw), 32'h1);
        req = '0;
        step(2);
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_id", 32'(rsp_id), 32'h1);
        chk("t1_color", 32'(rsp_color), 32'hFF0000);
        step(2);

        // Reset while in ADDR: lookup discarded, pointer back to 0.
        req = 4'b1000; set_idx(3, 3);
        step(1);
        chk("t4_gnt", 32'(gnt), 32'h8);
        #2 RST = 1'b1;
        step(1);
        chk("t4_rst_gnt", 32'(gnt), 32'h0);
        chk("t4_rst_sw", 32'(rom_sw), 32'h0);
        chk("t4_rst_valid", 32'(rsp_valid), 32'h0);
        req = '0;
        RST = 1'b0;
        step(4);

        // All requesters held: grants rotate 0,1,2,3 then wrap to 0.
        req = 4'b1111;
        set_idx(0, 0); set_idx(1, 1); set_idx(2, 2); set_idx(3, 3);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t2_gnt", 32'(gnt), 32'(1 << i));
            step(2);
            chk("t2_id", 32'(rsp_id), 32'(i));
            chk("t2_color", 32'(rsp_color), 32'(pal(i)));
        end
        step(1);
        chk("t2_wrap_gnt", 32'(gnt), 32'h1);
        req = '0;
        step(3);

        // Out-of-range index returns black.
        req = 4'b0100; set_idx(2, 9);
        step(1);
        chk("t3_rom_sw", 32'(rom_sw), 32'h9);
        req = '0;
        step(2);
        chk("t3_id", 32'(rsp_id), 32'h2);
        chk("t3_color", 32'(rsp_color), 32'h000000);
        step(2);

        // Index changed after capture: the captured index is used.
        req = 4'b0001; set_idx(0, 4);
        step(1);
        set_idx(0, 5);
        step(1);
        req = '0;
        step(1);
        chk("t5_color", 32'(rsp_color), 32'hFFFF00);
        step(3);
        chk("t5_sw_hold", 32'(rom_sw), 32'h4);

`ifdef PALETTE_ARB_BLANK_EN
        blank = 1'b1; req = 4'b0001; set_idx(0, 2);
        step(2);
        chk("blank_gnt", 32'(gnt), 32'h0);
        chk("blank_sw", 32'(rom_sw), 32'h7);
        blank = 1'b0;
        step(1);
        chk("unblank_gnt", 32'(gnt), 32'h1);
        req = '0;
        step(4);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
